irq_pending_latch: RTL and testbench

//  Upstream front end for the 16-to-4 priority encoder path: samples 16 request lines,

---
 rtl/irq_pkg.sv | 20 ++
 rtl/prio_enc_16.sv | 21 ++
 rtl/irq_pending_latch.sv | 106 ++++++++++
 tb/tb_irq_pending_latch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared sizes, FSM state type and helpers for the interrupt pending latch.
package irq_pkg;

    localparam int unsigned N_IRQ = 16;
    localparam int unsigned IDW   = 4;
    localparam int unsigned CNTW  = 8;

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_t;

    // One-hot mask selecting a single request line by index.
    function automatic logic [N_IRQ-1:0] idx_onehot(input logic [IDW-1:0] idx);
        return N_IRQ'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_enc_16.sv
// 16-to-4 priority encoder: highest set index wins, any flags a non-empty input.
module prio_enc_16
    import irq_pkg::*;
(
    input  logic [N_IRQ-1:0] elig_i,
    output logic             any_o,
    output logic [IDW-1:0]   idx_o
);

    // Scan upward so the last (highest) set bit overrides lower ones.
    always_comb begin
        any_o = |elig_i;
        idx_o = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (elig_i[i]) begin
                idx_o = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending latch for 16 request lines with a registered, held priority grant
// and a saturating counter of requests that arrive on already-pending lines.
module irq_pending_latch
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] mask,
    input  logic             ack,
    output logic             req_valid,
    output logic [IDW-1:0]   req_id,
    output logic [N_IRQ-1:0] pending,
    output logic [CNTW-1:0]  coal_cnt
);

    irq_state_t       state_q, state_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] irq_d_q;
    logic             req_valid_q, req_valid_d;
    logic [IDW-1:0]   req_id_q, req_id_d;
    logic [CNTW-1:0]  coal_cnt_q, coal_cnt_d;

    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] rise;
    logic             enc_any;
    logic [IDW-1:0]   enc_idx;

    // Only the registered pending bits compete; fresh requests wait one cycle.
    assign elig = pending_q & mask;

    prio_enc_16 u_prio_enc (
        .elig_i (elig),
        .any_o  (enc_any),
        .idx_o  (enc_idx)
    );

    // Grant FSM: take a winner in IDLE, hold it in PRESENT until acked.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_id_d    = req_id_q;
        clr         = '0;
        unique case (state_q)
            IDLE: begin
                if (enable && enc_any) begin
                    state_d     = PRESENT;
                    req_valid_d = 1'b1;
                    req_id_d    = enc_idx;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_d     = IDLE;
                    req_valid_d = 1'b0;
                    clr         = idx_onehot(req_id_q);
                end
            end
            default: begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // Pending update: new requests are ORed in after the clear, so a set in the ack cycle wins.
    always_comb begin
        pending_d = (pending_q & ~clr) | irq_in;
    end

    // Coalesce counter: one step per cycle with any new edge on an already-pending line.
    always_comb begin
        rise       = irq_in & ~irq_d_q;
        coal_cnt_d = coal_cnt_q;
        if ((|(rise & pending_q)) && (coal_cnt_q != CNT_MAX)) begin
            coal_cnt_d = coal_cnt_q + CNTW'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            irq_d_q     <= '0;
            req_valid_q <= 1'b0;
            req_id_q    <= '0;
            coal_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            irq_d_q     <= irq_in;
            req_valid_q <= req_valid_d;
            req_id_q    <= req_id_d;
            coal_cnt_q  <= coal_cnt_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_id    = req_id_q;
    assign pending   = pending_q;
    assign coal_cnt  = coal_cnt_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Scoreboard bench for irq_pending_latch: a driver advances a behavioural model and
// queues expectations; a monitor compares the DUT against them after each edge.
module tb_irq_pending_latch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] irq_in = '0;
    logic [15:0] mask = '0;
    logic        ack = 1'b0;
    logic        req_valid;
    logic [3:0]  req_id;
    logic [15:0] pending;
    logic [7:0]  coal_cnt;

    irq_pending_latch dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .irq_in    (irq_in),
        .mask      (mask),
        .ack       (ack),
        .req_valid (req_valid),
        .req_id    (req_id),
        .pending   (pending),
        .coal_cnt  (coal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pend;
        logic [7:0]  cnt;
        logic        v;
        logic [3:0]  id;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] gnt_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: set of pending lines, last sampled lines, counter, current grant.
    logic [15:0] m_pend = '0;
    logic [15:0] m_irqd = '0;
    int          m_cnt  = 0;
    bit          m_busy = 1'b0;
    logic [3:0]  m_id   = '0;

    task automatic do_check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] highest(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Drive one cycle of inputs, predict the post-edge state, then move to the next falling edge.
    task automatic step(input logic [15:0] irq, input logic [15:0] msk, input logic en, input logic ak);
        logic [15:0] clr;
        exp_t        e;
        irq_in = irq;
        mask   = msk;
        enable = en;
        ack    = ak;
        clr    = '0;
        if (m_busy && ak) clr[m_id] = 1'b1;
        if ((((irq & ~m_irqd) & m_pend) != 16'd0) && (m_cnt < 255)) m_cnt++;
        if (m_busy) begin
            if (ak) m_busy = 1'b0;
        end else if (en && ((m_pend & msk) != 16'd0)) begin
            m_id   = highest(m_pend & msk);
            m_busy = 1'b1;
            gnt_q.push_back(m_id);
        end
        m_pend = (m_pend & ~clr) | irq;
        m_irqd = irq;
        e.pend = m_pend;
        e.cnt  = 8'(m_cnt);
        e.v    = m_busy;
        e.id   = m_id;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Grant and ack until nothing is pending (bounded).
    task automatic drain();
        for (int k = 0; k < 80 && (m_pend != 16'd0 || m_busy); k++) begin
            step(16'h0000, 16'hFFFF, 1'b1, m_busy);
        end
        do_check("drain_empty", 32'(m_pend), 32'd0);
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock.
    task automatic do_reset(input logic [15:0] irq_val);
        exp_q.delete();
        gnt_q.delete();
        irq_in = irq_val;
        #2 rst = 1'b1;
        #1;
        do_check("rst_valid", 32'(req_valid), 32'd0);
        do_check("rst_id", 32'(req_id), 32'd0);
        do_check("rst_pending", 32'(pending), 32'd0);
        do_check("rst_coal", 32'(coal_cnt), 32'd0);
        repeat (2) @(negedge clk);
        do_check("rst_hold_pending", 32'(pending), 32'd0);
        rst    = 1'b0;
        m_pend = '0;
        m_irqd = '0;
        m_cnt  = 0;
        m_busy = 1'b0;
        m_id   = '0;
    endtask

    // Monitor: compare every post-edge state and every newly presented grant.
    logic prev_valid = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            do_check("pending", 32'(pending), 32'(e.pend));
            do_check("coal_cnt", 32'(coal_cnt), 32'(e.cnt));
            do_check("req_valid", 32'(req_valid), 32'(e.v));
            do_check("req_id", 32'(req_id), 32'(e.id));
        end
        if (req_valid && !prev_valid) begin
            if (gnt_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL grant: unexpected grant id %0d at %0t", req_id, $time);
            end else begin
                logic [3:0] g;
                g = gnt_q.pop_front();
                do_check("grant_id", 32'(req_id), 32'(g));
            end
        end
        prev_valid = req_valid;
    end

    initial begin
        @(negedge clk);
        // Reset with all lines high, then all 16 lines granted highest first.
        do_reset(16'hFFFF);
        step(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        step(16'h0000, 16'hFFFF, 1'b0, 1'b0);
        drain();

        // Single pulse on line 4.
        step(16'h0010, 16'hFFFF, 1'b1, 1'b0);
        step(16'h0000, 16'hFFFF, 1'b1, 1'b0);
        step(16'h0000, 16'hFFFF, 1'b1, 1'b0);
        drain();

        // Priority order 13, 10, 4.
        step(16'h2410, 16'hFFFF, 1'b1, 1'b0);
        drain();

        // Mask hides line 15; enable low blocks presentation.
        step(16'h8001, 16'h00FF, 1'b1, 1'b0);
        step(16'h0000, 16'h00FF, 1'b1, 1'b0);
        step(16'h0000, 16'h00FF, 1'b1, 1'b0);
        step(16'h0000, 16'h00FF, 1'b1, 1'b1);
        step(16'h0000, 16'h00FF, 1'b1, 1'b0);
        step(16'h0000, 16'h00FF, 1'b1, 1'b0);
        do_check("masked_still_pending", 32'(pending), 32'h8000);
        for (int k = 0; k < 4; k++) step(16'h0000, 16'hFFFF, 1'b0, 1'b1);
        do_check("enable_low_valid", 32'(req_valid), 32'd0);
        drain();

        // No pre-emption by line 15, then ack with line 3 re-asserted.
        step(16'h0008, 16'hFFFF, 1'b1, 1'b0);
        step(16'h0000, 16'hFFFF, 1'b1, 1'b0);
        step(16'h8000, 16'hFFFF, 1'b1, 1'b0);
        step(16'h0000, 16'hFFFF, 1'b1, 1'b0);
        do_check("no_preempt_id", 32'(req_id), 32'd3);
        step(16'h0008, 16'hFFFF, 1'b1, 1'b1);
        do_check("set_wins", 32'(pending[3]), 32'd1);
        step(16'h0000, 16'hFFFF, 1'b1, 1'b0);
        drain();

        // Coalesce saturation on line 2 with the grant held.
        step(16'h0004, 16'hFFFF, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) begin
            step(16'h0000, 16'hFFFF, 1'b1, 1'b0);
            step(16'h0004, 16'hFFFF, 1'b1, 1'b0);
        end
        do_check("coal_saturated", 32'(coal_cnt), 32'd255);
        do_check("pre_rst_valid", 32'(req_valid), 32'(m_busy));
        do_reset(16'h0000);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            logic [15:0] r_irq, r_msk;
            logic        r_en, r_ack;
            r_irq = 16'($urandom) & 16'($urandom) & 16'($urandom);
            r_msk = ~(16'($urandom) & 16'($urandom));
            r_en  = ($urandom_range(0, 9) != 0);
            r_ack = ($urandom_range(0, 2) == 0);
            step(r_irq, r_msk, r_en, r_ack);
        end
        drain();

        @(negedge clk);
        do_check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        do_check("grant_queue_empty", 32'(gnt_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
